// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver: one digit per refresh slot,
// whole value snapshotted once per frame, with leading-zero blanking and per-digit DPs.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        Clr,
    input  logic [15:0] Value,
    input  logic        Blank_LZ,
    input  logic [3:0]  DP_sel,
    output logic [3:0]  An,
    output logic [6:0]  Seg,
    output logic        DP,
    output logic        Frame
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST     = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(REFRESH_DIV - 2);

    logic [CW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic          valid_q, valid_d;
    logic [15:0]   val_q, val_d;
    logic          blz_q, blz_d;
    logic [3:0]    dps_q, dps_d;
    logic          frame_q, frame_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick;
    logic          blank_digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_decode = 7'b1000000;
            4'h1:    seg_decode = 7'b1111001;
            4'h2:    seg_decode = 7'b0100100;
            4'h3:    seg_decode = 7'b0110000;
            4'h4:    seg_decode = 7'b0011001;
            4'h5:    seg_decode = 7'b0010010;
            4'h6:    seg_decode = 7'b0000010;
            4'h7:    seg_decode = 7'b1111000;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    // A digit is a leading zero when it and every nibble above it are zero.
    function automatic logic digit_blanked(input logic [15:0] val, input logic blz,
                                           input logic [1:0] idx);
        logic [15:0] upper;
        upper = val >> {idx, 2'b00};
        digit_blanked = blz && (idx != 2'd0) && (upper == 16'h0000);
    endfunction

    always_comb begin
        tick        = (presc_q == LAST);
        presc_d     = tick ? '0 : presc_q + 1'b1;
        idx_d       = idx_q;
        valid_d     = valid_q;
        val_d       = val_q;
        blz_d       = blz_q;
        dps_d       = dps_q;
        an_d        = an_q;
        seg_d       = seg_q;
        dp_d        = dp_q;
        blank_digit = 1'b0;
        // Registered Frame is armed one cycle early so it is high during the 3->0 tick.
        frame_d     = (presc_q == PRE_LAST) && (idx_q == 2'd3);

        if (tick) begin
            idx_d   = idx_q + 2'd1;
            valid_d = 1'b1;
            if (idx_q == 2'd3) begin
                val_d = Value;
                blz_d = Blank_LZ;
                dps_d = DP_sel;
            end
        end

        // Outputs are loaded from next-state values so they change one cycle after the tick.
        if (tick && valid_d) begin
            blank_digit = digit_blanked(val_d, blz_d, idx_d);
            if (blank_digit) begin
                an_d  = 4'b1111;
                seg_d = 7'b1111111;
                dp_d  = 1'b1;
            end else begin
                an_d  = ~(4'b0001 << idx_d);
                seg_d = seg_decode(val_d[{idx_d, 2'b00} +: 4]);
                dp_d  = ~dps_d[idx_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Clr) begin
            presc_q <= '0;
            idx_q   <= 2'd3;
            valid_q <= 1'b0;
            val_q   <= '0;
            blz_q   <= 1'b0;
            dps_q   <= '0;
            frame_q <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            val_q   <= val_d;
            blz_q   <= blz_d;
            dps_q   <= dps_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign An    = an_q;
    assign Seg   = seg_q;
    assign DP    = dp_q;
    assign Frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-count reference model queues the
// expected display state each cycle and a monitor on the falling edge compares it.
module tb_seg7_scan_driver;

    localparam int DIV    = 4;
    localparam int PERIOD = 4 * DIV;

    logic        clk;
    logic        Clr;
    logic [15:0] Value;
    logic        Blank_LZ;
    logic [3:0]  DP_sel;
    logic [3:0]  An;
    logic [6:0]  Seg;
    logic        DP;
    logic        Frame;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       care;
        logic       frame;
    } exp_t;

    exp_t expq[$];

    seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .Clr      (Clr),
        .Value    (Value),
        .Blank_LZ (Blank_LZ),
        .DP_sel   (DP_sel),
        .An       (An),
        .Seg      (Seg),
        .DP       (DP),
        .Frame    (Frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input int n);
        case (n)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        int n;
        logic [15:0] r;
        n = 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
        n = (n + 1) % 10000;
        r = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
        return r;
    endfunction

    // Reference model: m_cyc counts cycles since reset ended; digit d of the latest
    // snapshot is shown during cycles DIV + 4k*DIV + d*DIV .. +DIV-1.
    int          m_cyc = 0;
    logic [15:0] m_val = '0;
    logic        m_blz = 1'b0;
    logic [3:0]  m_dp  = '0;

    always @(posedge clk) begin
        exp_t e;
        int   d;
        int   nib;
        e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, care: 1'b1, frame: 1'b0};
        if (Clr) begin
            m_cyc = 0;
            m_val = '0;
            m_blz = 1'b0;
            m_dp  = '0;
        end else begin
            if (m_cyc % PERIOD == DIV - 1) begin
                m_val = Value;
                m_blz = Blank_LZ;
                m_dp  = DP_sel;
            end
            m_cyc++;
            e.frame = (m_cyc % PERIOD == DIV - 1);
            if (m_cyc >= DIV) begin
                d   = ((m_cyc - DIV) / DIV) % 4;
                nib = int'((m_val >> (4 * d)) & 16'h000F);
                if (m_blz && d != 0 && (m_val >> (4 * d)) == 16'h0000) begin
                    e.an   = 4'b1111;
                    e.care = 1'b0;
                end else begin
                    e.an  = 4'(~(4'b0001 << d));
                    e.seg = seg_ref(nib);
                    e.dp  = ~m_dp[d];
                end
            end
        end
        expq.push_back(e);
    end

    int mon_cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            mon_cyc++;
            tests++;
            if ({An, Frame} !== {e.an, e.frame}) begin
                fails++;
                $display("FAIL anode/frame @%0d: got An=%b Frame=%b, expected An=%b Frame=%b",
                         mon_cyc, An, Frame, e.an, e.frame);
            end
            if (e.care) begin
                tests++;
                if ({Seg, DP} !== {e.seg, e.dp}) begin
                    fails++;
                    $display("FAIL seg/dp @%0d: got Seg=%b DP=%b, expected Seg=%b DP=%b",
                             mon_cyc, Seg, DP, e.seg, e.dp);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns during the cycle in which Frame is high; expiry counts as a failure.
    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            @(negedge clk);
            if (Frame === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL frame_wait: got no Frame pulse, expected one within %0d cycles",
                     4 * PERIOD);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of stimulus, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] cnt;
        Clr      = 1'b1;
        Value    = 16'h1234;
        Blank_LZ = 1'b0;
        DP_sel   = 4'b0000;
        cycles(3);
        Clr = 1'b0;

        // First frame, then a value change while digit 1 is on screen.
        cycles(10);
        Value = 16'h5678;
        cycles(30);

        Value    = 16'h0070;
        Blank_LZ = 1'b1;
        cycles(2 * PERIOD);
        Value = 16'h0000;
        cycles(2 * PERIOD);
        Value  = 16'h0A05;
        DP_sel = 4'b0010;
        cycles(2 * PERIOD);

        // Clear for one cycle while digit 2 is displayed.
        wait_frame();
        @(posedge clk);
        #1;
        cycles(8);
        Clr = 1'b1;
        cycles(1);
        Clr = 1'b0;
        cycles(PERIOD + 8);

        // Counter-driven value, one BCD increment per frame.
        Value    = 16'h9998;
        Blank_LZ = 1'b0;
        DP_sel   = 4'b0000;
        cnt      = 16'h9998;
        for (int f = 0; f < 4; f++) begin
            wait_frame();
            @(posedge clk);
            #1;
            cnt   = bcd_inc(cnt);
            Value = cnt;
        end
        cycles(PERIOD + 2);

        // Randomized inputs with occasional clears.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: Value = 16'($urandom);
                    1: Value = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                    2: Value = 16'($urandom_range(0, 255));
                    default: Value = 16'h0000;
                endcase
                Blank_LZ = 1'($urandom_range(0, 1));
                DP_sel   = 4'($urandom);
            end
            Clr = ($urandom_range(0, 149) == 0);
            cycles(1);
        end
        Clr = 1'b0;
        cycles(PERIOD);
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a four-digit common-anode seven-segment display. It consumes the 16-bit packed BCD value produced by the four-digit BCD counter and scans one digit per refresh tick, driving active-low anodes, segments and decimal point. The value is snapshotted once per scan frame so the display never shows a mix of old and new digits. Options: leading-zero blanking, per-digit decimal points, and a dash for non-BCD nibbles.

## Interface
- REFRESH_DIV, default 100000: clk cycles per digit slot. At 100 MHz this gives 1 kHz per digit and 250 Hz per frame. Legal range is 2 or more.
- clk  in  1  system clock; all state changes on the rising edge
- Clr  in  1  reset; synchronous, active-high
- Value  in  16  packed BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3
- Blank_LZ  in  1  1 = enable leading-zero blanking
- DP_sel  in  4  per-digit decimal point request, active-high; bit i belongs to digit i
- An  out  4  anode enables, active-low; An[i] selects digit i
- Seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- DP  out  1  decimal point, active-low
- Frame  out  1  one-cycle pulse when a new snapshot is taken

## Operation
- **Prescaler:** counts 0..REFRESH_DIV-1 and then wraps. Tick = (count == REFRESH_DIV-1).
- **Digit index (2 bits):** resets to 3. On each tick it advances 3→0→1→2→3.
- **Snapshot:** on a tick where the index goes 3→0, latch Value, Blank_LZ and DP_sel into frame registers and pulse Frame. Between snapshots, changes on the inputs have no effect on the display.
- **Valid flag:** cleared by reset, set on the first tick. While it is clear, all outputs stay at their blank values.
- **Output stage (all outputs registered):** one cycle after each tick, the outputs are loaded from the frame registers for the new index:
  - An: only bit [index] is low. If the digit is blanked, An = 4'b1111.
  - Seg: decode of the nibble.
  - DP = ~DP_sel_snap[index].
- **Decode (active-low):**
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - A–F = 0111111 (dash; segment g only)
- **Leading-zero blanking:** applies only when Blank_LZ_snap = 1.
  - Digit i (i = 3, 2, 1) is blanked if its nibble and every higher nibble are all 4'h0.
  - Digit 0 is never blanked.
  - A non-BCD nibble counts as nonzero.
  - A blanked digit also hides its DP, because its anode is off.
- **Reset:** Clr overrides everything, including a coincident tick.

## Timing
- Reset values:
  - An = 4'b1111, Seg = 7'b1111111, DP = 1, Frame = 0
  - prescaler = 0, index = 3, valid = 0, all frame registers = 0
- After Clr deasserts, the first tick comes on cycle REFRESH_DIV-1 (counting the first non-reset cycle as 0).
  - That tick drives index 3→0, takes the snapshot and pulses Frame in the same cycle.
  - The digit-0 outputs appear on the next cycle.
- Latency from tick to output change is 1 cycle. Each digit is displayed for exactly REFRESH_DIV cycles.
- Value sampled at the 3→0 tick is visible on digit 0 one cycle later. Digits 1, 2 and 3 show the same snapshot in the following slots.
- Frame is high for exactly 1 cycle every 4·REFRESH_DIV cycles.
- Clr mid-frame: on the next cycle the outputs are blank and the sequence restarts as from power-up. No partial frame resumes.
- REFRESH_DIV = 2 must work: ticks on every other cycle, and the outputs still lag each tick by 1 cycle.

## Test plan
- Run with REFRESH_DIV = 4.
- **Reset and first frame:** Clr for 3 cycles, Value = 16'h1234, Blank_LZ = 0, DP_sel = 0.
  - Outputs stay blank until the first tick at cycle 3.
  - Frame pulses at cycle 3.
  - From cycle 4: An = 1110, Seg = 0011001 ("4").
  - Then An = 1101 with "3", 1011 with "2", 0111 with "1", each held for 4 cycles.
- **Snapshot integrity:** change Value from 16'h1234 to 16'h5678 while digit 1 is displayed.
  - Digits 2 and 3 still show 2 and 1.
  - After the next Frame, digit 0 shows "8".
- **Leading-zero blanking:** Value = 16'h0070, Blank_LZ = 1.
  - Digits 3 and 2 have An = 1111.
  - Digit 1 shows "7"; digit 0 shows "0".
  - With Value = 16'h0000, only digit 0 lights, showing "0".
- **Invalid nibble and DP:** Value = 16'h0A05, Blank_LZ = 1, DP_sel = 4'b0010.
  - Digit 2 shows dash 0111111.
  - Digit 3 is blanked.
  - Digit 1 shows "0" with DP = 0.
  - All other displayed digits have DP = 1.
- **Mid-frame reset:** assert Clr for 1 cycle while digit 2 is displayed.
  - Next cycle: An = 1111, Seg = 1111111, DP = 1.
  - Frame pulses again exactly 4 cycles after Clr deasserts (count 0..3).
- **Counter integration:** drive Value from the BCD counter, counting up from 16'h9998 at one increment per frame.
  - Snapshots read 9998, 9999, 0000 on successive frames.
  - No frame shows a mixed value.
